// File: rtl/parallel_block_dispatcher_pkg.sv
// Shared configuration for the parallel block dispatcher: default geometry,
// FSM state encoding and width helpers.
package parallel_block_dispatcher_pkg;

    localparam int DEF_N_CH   = 4;
    localparam int DEF_VDIM   = 2;
    localparam int DEF_WBW    = 16;
    localparam int DEF_CREDIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_DRAIN    = 2'd2
    } dispatch_state_t;

    // Credit counters must hold the value CREDIT itself.
    function automatic int credit_width(input int credit);
        return $clog2(credit + 1);
    endfunction

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/parallel_block_dispatcher_rr_arbiter_mask.sv
// Combinational round-robin picker: one-hot grant of the first set bit of
// the eligible mask at or after rr_ptr (wrapping), plus a valid flag.
module rr_arbiter_mask #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     eligible,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    logic [2*N-1:0] rot_dbl;
    logic [2*N-1:0] back_dbl;
    logic [N-1:0]   rot_mask;
    logic [N-1:0]   rot_grant;

    always_comb begin
        // Rotate right so rr_ptr lands on bit 0, pick lowest set bit, rotate back.
        rot_dbl   = {eligible, {N{1'b0}}} >> rr_ptr;
        rot_mask  = rot_dbl[2*N-1:N] | rot_dbl[N-1:0];
        rot_grant = rot_mask & (-rot_mask);
        back_dbl  = {{N{1'b0}}, rot_grant} << rr_ptr;
        grant     = back_dbl[2*N-1:N] | back_dbl[N-1:0];
        valid     = |eligible;
    end

endmodule

// File: rtl/parallel_block_dispatcher.sv
// Walks a VDIM-dimensional block grid and offers each block to credit-limited
// channels round-robin. Optional stall counter: PARALLEL_BLOCK_DISPATCHER_STATS_EN.
module parallel_block_dispatcher
    import parallel_block_dispatcher_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int VDIM   = DEF_VDIM,
    parameter int WBW    = DEF_WBW,
    parameter int CREDIT = DEF_CREDIT
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                src_rdy,
    output logic                src_ack,
    input  logic [VDIM*WBW-1:0] i_bgrid_step,
    input  logic [VDIM*WBW-1:0] i_bgrid_end,
    output logic [N_CH-1:0]     bofs_rdys,
    input  logic [N_CH-1:0]     bofs_acks,
    output logic [VDIM*WBW-1:0] o_bofs,
    input  logic [N_CH-1:0]     blkdone_dvals,
    output logic                o_busy
`ifdef PARALLEL_BLOCK_DISPATCHER_STATS_EN
    ,
    output logic [31:0]         o_stall_cycles
`endif
);

    localparam int CW   = credit_width(CREDIT);
    localparam int RR_W = ptr_width(N_CH);
    localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT);
    localparam logic [CW-1:0] CREDIT_ONE  = CW'(1);

    dispatch_state_t state_reg, state_next;

    logic [VDIM*WBW-1:0] step_reg, end_reg, ofs_reg, ofs_adv;
    logic [N_CH-1:0]     offer_reg, eligible, credit_full, grant;
    logic [RR_W-1:0]     rr_reg, rr_next;
    logic [VDIM-1:0]     dim_wrap, carry_in, end_zero;
    logic                ack_reg, grant_valid, last_blk;
    logic                start_job, ack_fire, select_now, ack_now;

    // Odometer: dim VDIM-1 is innermost; a dim steps only when all inner dims wrap.
    for (genvar gi = 0; gi < VDIM; gi++) begin : g_dim
        localparam logic [VDIM-1:0] INNER_MASK = VDIM'((1 << (gi + 1)) - 1);
        logic [WBW:0] dim_sum;

        assign dim_sum      = {1'b0, ofs_reg[gi*WBW +: WBW]} + {1'b0, step_reg[gi*WBW +: WBW]};
        assign dim_wrap[gi] = (dim_sum >= {1'b0, end_reg[gi*WBW +: WBW]});
        assign carry_in[gi] = &(dim_wrap | INNER_MASK);
        assign end_zero[gi] = (i_bgrid_end[gi*WBW +: WBW] == '0);
        assign ofs_adv[gi*WBW +: WBW] = !carry_in[gi] ? ofs_reg[gi*WBW +: WBW] :
                                        dim_wrap[gi]  ? '0 : dim_sum[WBW-1:0];
    end

    assign last_blk = &dim_wrap;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic [CW-1:0] credit_reg;

        assign eligible[gi]    = (credit_reg != '0);
        assign credit_full[gi] = (credit_reg == CREDIT_FULL);

        // A blkdone arriving with the ack cancels it; one at full credit is dropped.
        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                credit_reg <= CREDIT_FULL;
            end else if (ack_fire && offer_reg[gi]) begin
                if (!blkdone_dvals[gi]) begin
                    credit_reg <= credit_reg - CREDIT_ONE;
                end
            end else if (blkdone_dvals[gi] && !credit_full[gi]) begin
                credit_reg <= credit_reg + CREDIT_ONE;
            end
        end

`ifdef PARALLEL_BLOCK_DISPATCHER_STATS_EN
        a_blkdone_at_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
            !(blkdone_dvals[gi] && credit_full[gi]));
`endif
    end

    rr_arbiter_mask #(
        .N     (N_CH),
        .PTR_W (RR_W)
    ) u_arb (
        .eligible (eligible),
        .rr_ptr   (rr_reg),
        .grant    (grant),
        .valid    (grant_valid)
    );

    always_comb begin
        rr_next = rr_reg;
        for (int c = 0; c < N_CH; c++) begin
            if (offer_reg[c]) begin
                rr_next = RR_W'((c + 1) % N_CH);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        start_job  = 1'b0;
        ack_fire   = 1'b0;
        select_now = 1'b0;
        ack_now    = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                // The ack cycle itself is idle time; a still-high src_rdy is stale.
                if (src_rdy && !ack_reg) begin
                    start_job  = 1'b1;
                    state_next = (|end_zero) ? ST_DRAIN : ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                if (offer_reg == '0) begin
                    select_now = grant_valid;
                end else if (|(bofs_acks & offer_reg)) begin
                    ack_fire = 1'b1;
                    if (last_blk) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (&credit_full) begin
                    ack_now    = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_reg <= ST_IDLE;
            step_reg  <= '0;
            end_reg   <= '0;
            ofs_reg   <= '0;
            offer_reg <= '0;
            rr_reg    <= '0;
            ack_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ack_reg   <= ack_now;
            if (start_job) begin
                step_reg <= i_bgrid_step;
                end_reg  <= i_bgrid_end;
                ofs_reg  <= '0;
            end
            if (select_now) begin
                offer_reg <= grant;
            end
            if (ack_fire) begin
                offer_reg <= '0;
                rr_reg    <= rr_next;
                ofs_reg   <= ofs_adv;
            end
        end
    end

    assign src_ack   = ack_reg;
    assign bofs_rdys = offer_reg;
    assign o_bofs    = ofs_reg;
    assign o_busy    = (state_reg != ST_IDLE);

`ifdef PARALLEL_BLOCK_DISPATCHER_STATS_EN
    logic [31:0] stall_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || start_job) begin
            stall_reg <= '0;
        end else if (state_reg == ST_DISPATCH && offer_reg == '0 && !grant_valid
                     && stall_reg != '1) begin
            stall_reg <= stall_reg + 32'd1;
        end
    end

    assign o_stall_cycles = stall_reg;
`endif

endmodule
